// File: rtl/display_scan_mux.sv
// display_scan_mux: scans NUM_DIGITS 7-segment digits with hex decode, a dead-time cycle between digits, leading-zero blanking and frame-safe double buffering.
// Latency: anode/seg/dp/frame_done are registered, one cycle behind the scan state (prescaler, idx, dead, shadow).
// Backpressure: none; load is a fire-and-forget strobe and the most recent load before a frame wrap is what the next frame shows.
module display_scan_mux #(
    parameter int NUM_DIGITS       = 4,
    parameter int SCAN_DIV         = 50000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit BLANK_LEADING    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic DP_OFF = SEG_ACTIVE_LOW;

    // Hex nibble to active-high segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    logic [PW-1:0]           pre;
    logic [IW-1:0]           idx;
    logic                    dead;
    logic [4*NUM_DIGITS-1:0] hold_dig;
    logic [NUM_DIGITS-1:0]   hold_dp;
    logic [4*NUM_DIGITS-1:0] shadow_dig;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    load_pending;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    run_zero;
    logic [NUM_DIGITS-1:0]   sel;

    assign tick = enable && (pre == PRE_LAST);
    assign wrap = tick && (idx == IDX_LAST);
    assign sel  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

    // Select the current digit's nibble/dp and decide leading-zero blanking
    // by walking from the most significant digit down, tracking "all zero so far".
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        run_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero = run_zero && (shadow_dig[4*i +: 4] == 4'h0) && !shadow_dp[i];
            if (idx == IW'(i)) begin
                cur_nib   = shadow_dig[4*i +: 4];
                cur_dp    = shadow_dp[i];
                cur_blank = BLANK_LEADING && (i != 0) && run_zero;
            end
        end
    end

    // Prescaler, digit index and the one-cycle dead-time flag after each slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre  <= '0;
            idx  <= '0;
            dead <= 1'b0;
        end else if (!enable) begin
            pre  <= '0;
            idx  <= '0;
            dead <= 1'b0;
        end else if (tick) begin
            pre  <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            dead <= 1'b1;
        end else begin
            pre  <= pre + 1'b1;
            dead <= 1'b0;
        end
    end

    // Hold register takes every load; shadow only changes on a frame wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_dig     <= '0;
            hold_dp      <= '0;
            shadow_dig   <= '0;
            shadow_dp    <= '0;
            load_pending <= 1'b0;
        end else begin
            if (load) begin
                hold_dig <= digits_in;
                hold_dp  <= dp_in;
            end
            if (wrap && load) begin
                shadow_dig   <= digits_in;
                shadow_dp    <= dp_in;
                load_pending <= 1'b0;
            end else if (wrap && load_pending) begin
                shadow_dig   <= hold_dig;
                shadow_dp    <= hold_dp;
                load_pending <= 1'b0;
            end else if (load) begin
                load_pending <= 1'b1;
            end
        end
    end

    // Registered pin drive with polarity applied; dark during dead time or when disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode      <= ANODE_OFF;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (!enable || dead) begin
                anode <= ANODE_OFF;
                seg   <= SEG_OFF;
                dp    <= DP_OFF;
            end else begin
                anode <= ANODE_ACTIVE_LOW ? ~sel : sel;
                if (cur_blank)
                    seg <= SEG_OFF;
                else
                    seg <= SEG_ACTIVE_LOW ? ~decode(cur_nib) : decode(cur_nib);
                dp <= SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: randomized and directed stimulus for display_scan_mux (4 digits, 4 clocks per slot).
// Expected pins come from an elapsed-cycle model: slot and digit are derived arithmetically from cycles since enable.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_display_scan_mux;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int FR = N * D;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic           load;
    logic [4*N-1:0] digits_in;
    logic [N-1:0]   dp_in;
    logic [N-1:0]   anode;
    logic [6:0]     seg;
    logic           dp;
    logic           frame_done;

    always #5 clk = ~clk;

    display_scan_mux #(
        .NUM_DIGITS(N),
        .SCAN_DIV(D),
        .ANODE_ACTIVE_LOW(1'b1),
        .SEG_ACTIVE_LOW(1'b1),
        .BLANK_LEADING(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .load(load),
        .digits_in(digits_in),
        .dp_in(dp_in),
        .anode(anode),
        .seg(seg),
        .dp(dp),
        .frame_done(frame_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Active-high segment patterns for 0..F
    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Reference model state
    int             t;          // enabled clock edges since scanning (re)started
    logic [4*N-1:0] m_shadow;
    logic [N-1:0]   m_shdp;
    logic [4*N-1:0] m_hold;
    logic [N-1:0]   m_hdp;
    bit             m_pend;
    logic [N-1:0]   e_anode;
    logic [6:0]     e_seg;
    logic           e_dp;
    logic           e_fd;

    task automatic set_dark();
        e_anode = '1;
        e_seg   = 7'h7F;
        e_dp    = 1'b1;
    endtask

    task automatic model_reset();
        t        = 0;
        m_shadow = '0;
        m_shdp   = '0;
        m_hold   = '0;
        m_hdp    = '0;
        m_pend   = 1'b0;
        set_dark();
        e_fd     = 1'b0;
    endtask

    // Digit i is blank when it is not digit 0 and it and every higher digit are zero without dp
    function automatic logic [6:0] exp_seg(input int i);
        bit   blank;
        logic [3:0] nib;
        nib   = m_shadow[i*4 +: 4];
        blank = (i > 0);
        for (int j = i; j < N; j++)
            if (m_shadow[j*4 +: 4] != 4'h0 || m_shdp[j]) blank = 1'b0;
        return blank ? 7'h7F : ~seg_tab[nib];
    endfunction

    // Expected pins after this clock edge, then advance the model
    task automatic model_step();
        int           d_idx;
        bit           is_dead;
        bit           wrap;
        logic [N-1:0] one;
        one  = 1;
        wrap = 1'b0;
        if (!enable) begin
            set_dark();
            t = 0;
        end else begin
            d_idx   = (t / D) % N;
            is_dead = (t > 0) && (t % D == 0);
            if (is_dead) begin
                set_dark();
            end else begin
                e_anode = ~(one << d_idx);
                e_seg   = exp_seg(d_idx);
                e_dp    = ~m_shdp[d_idx];
            end
            wrap = ((t % FR) == FR - 1);
        end
        e_fd = wrap;
        if (load) begin
            m_hold = digits_in;
            m_hdp  = dp_in;
            m_pend = 1'b1;
        end
        if (wrap && m_pend) begin
            m_shadow = m_hold;
            m_shdp   = m_hdp;
            m_pend   = 1'b0;
        end
        if (enable) t++;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".anode"}, 32'(anode), 32'(e_anode));
        chk({tag, ".seg"}, 32'(seg), 32'(e_seg));
        chk({tag, ".dp"}, 32'(dp), 32'(e_dp));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(e_fd));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; enable = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // Bring-up with 1234
        enable = 1'b1; load = 1'b1; digits_in = 16'h1234; dp_in = 4'h0;
        cyc("load1234");
        load = 1'b0;
        repeat (2 * FR) cyc("scan1234");

        // Mid-frame load must not tear the current frame
        repeat (5) cyc("pre0005");
        load = 1'b1; digits_in = 16'h0005;
        cyc("load0005");
        load = 1'b0;
        repeat (2 * FR) cyc("scan0005");

        // Decimal point on digit 2 stops blanking from there down
        load = 1'b1; dp_in = 4'b0100;
        cyc("loaddp");
        load = 1'b0;
        repeat (2 * FR) cyc("scandp");

        // Load coincident with the wrapping tick
        k = 0;
        while (((t % FR) != FR - 1) && k < 100) begin
            cyc("align");
            k++;
        end
        if (k >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL align: got no wrap within %0d cycles expected a wrap", k);
        end
        load = 1'b1; digits_in = 16'hABCD; dp_in = 4'h0;
        cyc("loadwrap");
        load = 1'b0;
        repeat (3 * FR) cyc("scanABCD");

        // Enable low for 10 cycles mid-slot
        repeat (6) cyc("preen");
        enable = 1'b0;
        repeat (10) cyc("enlow");
        enable = 1'b1;
        repeat (2 * FR) cyc("enrise");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (enable) begin
                if ($urandom_range(0, 99) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                enable = 1'b1;
            end
            load = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: digits_in = 16'($urandom);
                1: digits_in = {12'h000, 4'($urandom)};
                2: digits_in = {8'h00, 8'($urandom)};
                default: digits_in = 16'h0000;
            endcase
            dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            cyc("rand");
        end
        load = 1'b0; enable = 1'b1;
        repeat (FR + 3) cyc("settle");

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("arst");
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs("arst_hold");
        end
        rst = 1'b0; enable = 1'b0;
        repeat (2) cyc("post_rst_off");
        enable = 1'b1;
        repeat (2 * FR) cyc("post_rst_scan");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
